// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, nibble width and sequencer state encoding
package alu_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ALU_XOR = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_word_sequencer.sv
// rtl/alu_word_sequencer.sv - runs a WORD_W-bit op through an external 4-bit ALU one nibble per cycle
module alu_word_sequencer
  import alu_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              busy,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic              alu_cin,
  output logic [1:0]        alu_sel,
  input  logic [3:0]        alu_result,
  input  logic              alu_carry
);

  localparam int NIB   = WORD_W / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [1:0]          op_q;
  logic [WORD_W-1:0]   a_q;
  logic [WORD_W-1:0]   b_q;
  logic [WORD_W-1:0]   res_q;
  logic                cin_q;
  logic                carry_reg;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [WORD_W-1:0]   res_next;
  logic                is_arith;
  logic                ovf_next;

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_result = res_q;

  // Select the current operand nibbles and fold the incoming ALU nibble into the result word
  always_comb begin
    a_nib    = a_q[NIBBLE_W*idx +: NIBBLE_W];
    b_nib    = b_q[NIBBLE_W*idx +: NIBBLE_W];
    res_next = res_q;
    res_next[NIBBLE_W*idx +: NIBBLE_W] = alu_result;
    is_arith = op_q[1];
    if (op_q == ALU_ADD) begin
      ovf_next = (a_q[WORD_W-1] == b_q[WORD_W-1]) && (res_next[WORD_W-1] != a_q[WORD_W-1]);
    end else if (op_q == ALU_SUB) begin
      ovf_next = (a_q[WORD_W-1] != b_q[WORD_W-1]) && (res_next[WORD_W-1] != a_q[WORD_W-1]);
    end else begin
      ovf_next = 1'b0;
    end
  end

  // ALU drive; SUB upper nibbles use ADD with inverted B since sel=11 would force cin=1
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_sel = ALU_XOR;
    if (state == RUN) begin
      alu_a = a_nib;
      case (op_q)
        ALU_XOR, ALU_AND: begin
          alu_sel = op_q;
          alu_b   = b_nib;
        end
        ALU_ADD: begin
          alu_sel = ALU_ADD;
          alu_b   = b_nib;
          alu_cin = (idx == '0) ? cin_q : carry_reg;
        end
        ALU_SUB: begin
          if (idx == '0) begin
            alu_sel = ALU_SUB;
            alu_b   = b_nib;
          end else begin
            alu_sel = ALU_ADD;
            alu_b   = ~b_nib;
            alu_cin = carry_reg;
          end
        end
        default: begin
          alu_sel = ALU_XOR;
        end
      endcase
    end
  end

  // Sequencer FSM: latch request, step nibbles with carry chaining, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      op_q         <= ALU_XOR;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      carry_reg    <= 1'b0;
      res_q        <= '0;
      out_valid    <= 1'b0;
      out_carry    <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= in_op;
            a_q       <= in_a;
            b_q       <= in_b;
            cin_q     <= in_cin;
            idx       <= '0;
            carry_reg <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          res_q     <= res_next;
          carry_reg <= alu_carry;
          if (idx == LAST_IDX) begin
            idx          <= '0;
            state        <= DONE;
            out_valid    <= 1'b1;
            out_carry    <= is_arith & alu_carry;
            out_zero     <= ~|res_next;
            out_overflow <= ovf_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
